power_of_2n_pipe: RTL and testbench

//   Parametrised pipelined power unit: computes x^(2^STAGES) by repeated squaring, one squarer per stage.

---
 rtl/power_of_2n_pipe_if.sv | 24 ++
 rtl/power_of_2n_pipe.sv | 71 +++++++
 tb/tb_power_of_2n_pipe.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/power_of_2n_pipe_if.sv
// Valid/ready bus for the repeated-squaring power pipeline.
// Producer drives i_valid/i_value, consumer drives i_ready.
interface power_of_2n_pipe_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 64
);
  logic             i_valid;
  logic [IN_W-1:0]  i_value;
  logic             o_ready;
  logic             o_valid;
  logic [OUT_W-1:0] o_power;
  logic             o_overflow;
  logic             i_ready;

  modport master (
    output i_valid, i_value, i_ready,
    input  o_ready, o_valid, o_power, o_overflow
  );

  modport slave (
    input  i_valid, i_value, i_ready,
    output o_ready, o_valid, o_power, o_overflow
  );
endinterface

// File: rtl/power_of_2n_pipe.sv
// Pipelined x^(2^STAGES): one squarer per stage, elastic
// valid/ready stages with bubble collapse and sticky overflow.
module power_of_2n_pipe #(
  parameter int IN_W   = 32,
  parameter int OUT_W  = 64,
  parameter int STAGES = 3
) (
  input logic               clk,
  input logic               reset_n,
  power_of_2n_pipe_if.slave bus
);
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] ovf;
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] in_vld;
  logic [STAGES-1:0] in_ovf;
  logic [OUT_W-1:0]  val    [STAGES];
  logic [OUT_W-1:0]  in_val [STAGES];

  // Stage k can move iff i_ready or any stage at or after k is empty.
  always_comb begin
    rdy = '0;
    for (int k = 0; k < STAGES; k++) begin
      rdy[k] = bus.i_ready;
      for (int j = k; j < STAGES; j++)
        rdy[k] = rdy[k] | ~vld[j];
    end
  end

  assign in_vld[0] = bus.i_valid;
  assign in_val[0] = OUT_W'(bus.i_value[IN_W-1:0]);
  assign in_ovf[0] = 1'b0;

  for (genvar k = 1; k < STAGES; k++) begin : g_link
    assign in_vld[k] = vld[k-1];
    assign in_val[k] = val[k-1];
    assign in_ovf[k] = ovf[k-1];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [2*OUT_W-1:0] p;
    logic               v_q;
    logic               o_q;
    logic [OUT_W-1:0]   d_q;

    assign p = (2*OUT_W)'(in_val[k]) * (2*OUT_W)'(in_val[k]);

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        v_q <= 1'b0;
        d_q <= '0;
        o_q <= 1'b0;
      end else if (rdy[k]) begin
        v_q <= in_vld[k];
        if (in_vld[k]) begin
          d_q <= p[OUT_W-1:0];
          o_q <= in_ovf[k] | (|p[2*OUT_W-1:OUT_W]);
        end
      end
    end

    assign vld[k] = v_q;
    assign val[k] = d_q;
    assign ovf[k] = o_q;
  end

  assign bus.o_ready    = rdy[0];
  assign bus.o_valid    = vld[STAGES-1];
  assign bus.o_power    = val[STAGES-1];
  assign bus.o_overflow = ovf[STAGES-1];
endmodule

// File: tb/tb_power_of_2n_pipe.sv
// Random and directed bench for power_of_2n_pipe against a
// scoreboard fed by a plain multiply-E-times reference model.
module tb_power_of_2n_pipe;
  localparam int STAGES = 3;
  localparam int EXP    = 1 << STAGES;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  power_of_2n_pipe_if #(.IN_W(32), .OUT_W(64)) bus ();
  power_of_2n_pipe_if #(.IN_W(8),  .OUT_W(16)) b1 ();
  power_of_2n_pipe_if #(.IN_W(32), .OUT_W(64)) b4 ();

  power_of_2n_pipe #(.IN_W(32), .OUT_W(64), .STAGES(STAGES)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  power_of_2n_pipe #(.IN_W(8), .OUT_W(16), .STAGES(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(b1)
  );
  power_of_2n_pipe #(.IN_W(32), .OUT_W(64), .STAGES(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .bus(b4)
  );

  typedef struct {
    logic [63:0] pw;
    bit          ov;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] qin[$];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          held = 1'b0;
  logic [63:0] held_pw;
  bit          held_ov;
  bit          last_rdy;
  logic [63:0] last_pw;
  bit          last_ov;
  int          iter = 0;
  int          first_acc = -1;
  int          first_out = -1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // x^EXP by EXP plain multiplies; overflow once the exact power passes 64 bits.
  function automatic void model(input logic [31:0] x,
                                output logic [63:0] pw, output bit ov);
    logic [127:0] acc;
    acc = 128'd1;
    ov  = 1'b0;
    for (int i = 0; i < EXP; i++) begin
      acc = acc * {96'd0, x};
      if (acc[127:64] != 64'd0) ov = 1'b1;
      acc = {64'd0, acc[63:0]};
    end
    pw = acc[63:0];
  endfunction

  task automatic step(input bit v, input logic [31:0] x, input bit r,
                      output bit acc);
    exp_t e;
    @(negedge clk);
    iter++;
    if (held) begin
      chk("hold_vld", 64'(bus.o_valid), 64'd1);
      chk("hold_pw", bus.o_power, held_pw);
      chk("hold_ov", 64'(bus.o_overflow), 64'(held_ov));
    end
    bus.i_valid = v;
    bus.i_value = x;
    bus.i_ready = r;
    #1;
    last_rdy = bus.o_ready;
    acc = v && bus.o_ready;
    if (acc) begin
      model(x, e.pw, e.ov);
      sb.push_back(e);
      if (first_acc < 0) first_acc = iter;
    end
    held    = bus.o_valid && !r;
    held_pw = bus.o_power;
    held_ov = bus.o_overflow;
    if (bus.o_valid && r) begin
      if (first_out < 0) first_out = iter;
      if (sb.size() == 0) begin
        chk("spurious", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("power", bus.o_power, e.pw);
        chk("ovf", 64'(bus.o_overflow), 64'(e.ov));
        last_pw = bus.o_power;
        last_ov = bus.o_overflow;
      end
    end
  endtask

  task automatic drain(input int budget);
    bit a;
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      step(1'b0, 32'd0, 1'b1, a);
      n++;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
  endtask

  task automatic single(input logic [31:0] x);
    bit a;
    step(1'b1, x, 1'b1, a);
    drain(10);
  endtask

  initial begin
    bit a;
    int c;
    bus.i_valid = 1'b0;
    bus.i_value = '0;
    bus.i_ready = 1'b1;
    b1.i_valid = 1'b0;
    b1.i_value = '0;
    b1.i_ready = 1'b1;
    b4.i_valid = 1'b0;
    b4.i_value = '0;
    b4.i_ready = 1'b1;

    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_vld", 64'(bus.o_valid), 64'd0);
    chk("rst_pw", bus.o_power, 64'd0);
    chk("rst_ov", 64'(bus.o_overflow), 64'd0);
    chk("rst_rdy", 64'(bus.o_ready), 64'd1);

    for (int x = 0; x < 100; x++) qin.push_back(32'(x));
    c = 0;
    while (qin.size() > 0 && c < 500) begin
      step(1'b1, qin[0], 1'b1, a);
      if (a) void'(qin.pop_front());
      c++;
    end
    chk("t1_in_left", 64'(qin.size()), 64'd0);
    chk("t1_thru", 64'(c), 64'd100);
    drain(50);
    chk("t1_latency", 64'(first_out - first_acc), 64'd3);

    single(32'd255);
    chk("x255_pw", last_pw, 64'd17878103347812890625);
    chk("x255_ov", 64'(last_ov), 64'd0);
    single(32'd256);
    chk("x256_pw", last_pw, 64'd0);
    chk("x256_ov", 64'(last_ov), 64'd1);
    single(32'hFFFF_FFFF);
    chk("xmax_ov", 64'(last_ov), 64'd1);

    for (int x = 0; x < 20; x++) qin.push_back(32'(x));
    c = 0;
    while (qin.size() > 0 && c < 200) begin
      step(1'b1, qin[0], !(c >= 5 && c < 11), a);
      if (a) void'(qin.pop_front());
      if (c == 10) chk("stall_rdy", 64'(last_rdy), 64'd0);
      c++;
    end
    chk("t3_in_left", 64'(qin.size()), 64'd0);
    drain(50);

    step(1'b1, 32'd2, 1'b0, a);
    chk("pk_acc2", 64'(a), 64'd1);
    step(1'b1, 32'd3, 1'b0, a);
    chk("pk_acc3", 64'(a), 64'd1);
    step(1'b1, 32'd4, 1'b0, a);
    chk("pk_acc4", 64'(a), 64'd1);
    step(1'b0, 32'd0, 1'b0, a);
    chk("pk_full_rdy", 64'(last_rdy), 64'd0);
    step(1'b0, 32'd0, 1'b1, a);
    chk("pk_out0", last_pw, 64'd256);
    step(1'b0, 32'd0, 1'b1, a);
    chk("pk_out1", last_pw, 64'd6561);
    step(1'b0, 32'd0, 1'b1, a);
    chk("pk_out2", last_pw, 64'd65536);
    chk("pk_empty", 64'(sb.size()), 64'd0);

    step(1'b1, 32'd7, 1'b0, a);
    step(1'b1, 32'd8, 1'b0, a);
    step(1'b1, 32'd9, 1'b0, a);
    @(negedge clk);
    reset_n = 1'b0;
    bus.i_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    sb.delete();
    held = 1'b0;
    #1;
    chk("mid_rst_vld", 64'(bus.o_valid), 64'd0);
    single(32'd5);
    chk("x5_pw", last_pw, 64'd390625);
    repeat (5) step(1'b0, 32'd0, 1'b1, a);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] x;
      case ($urandom % 3)
        0:       x = $urandom % 300;
        1:       x = $urandom;
        default: x = $urandom % 65536;
      endcase
      step(($urandom % 4) != 0, x, ($urandom % 10) < 7, a);
    end
    drain(100);

    bus.i_valid = 1'b0;
    @(negedge clk);
    b1.i_valid = 1'b1;
    b1.i_value = 8'd255;
    b4.i_valid = 1'b1;
    b4.i_value = 32'd3;
    @(negedge clk);
    b1.i_valid = 1'b0;
    b4.i_valid = 1'b0;
    chk("s1_vld", 64'(b1.o_valid), 64'd1);
    chk("s1_pw", 64'(b1.o_power), 64'd65025);
    chk("s1_ov", 64'(b1.o_overflow), 64'd0);
    repeat (2) @(negedge clk);
    chk("s4_early", 64'(b4.o_valid), 64'd0);
    @(negedge clk);
    chk("s4_vld", 64'(b4.o_valid), 64'd1);
    chk("s4_pw", b4.o_power, 64'd43046721);
    chk("s4_ov", 64'(b4.o_overflow), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
